instruction_cache_responder: RTL and testbench
==============================================

// Module: instruction_cache_responder
// PURPOSE
// - Responder end of the fetch-to-cache read interface. Accepts fetch-stage read
//   requests (address + read enable) and returns one 64-bit instruction word with
//   a data-valid pulse.
// - Direct-mapped, read-only instruction cache. Misses are refilled over a
//   burst-read memory port.
// - Sits between the instruction fetch stage and the memory/bus interface.
// PARAMETERS
// - ADDR_W      64  request/memory address width
// - DATA_W      64  word width; one memory beat per word
// - LINE_BYTES  32  line size; LINE_WORDS = LINE_BYTES/8 = 4 beats per refill
// - SETS        64  number of lines; index = addr[10:5]; tag = addr[ADDR_W-1:11] (defaults)
// PORTS
// - clk             in   1       clock, rising edge
// - reset           in   1       asynchronous, active-low reset
// - read_enable     in   1       fetch request valid
// - address         in   ADDR_W  fetch byte address; addr[2:0] ignored (word aligned)
// - req_ready       out  1       request accepted when read_enable && req_ready
// - flush           in   1       invalidate all lines (fence.i)
// - read_data       out  DATA_W  returned instruction word
// - data_valid      out  1       one-cycle pulse; read_data valid in that cycle only
// - mem_req_valid   out  1       refill request; held high until mem_req_ready
// - mem_req_ready   in   1       memory accepts refill request
// - mem_req_addr    out  ADDR_W  line-aligned refill address (low 5 bits zero)
// - mem_resp_valid  in   1       refill beat valid; beats arrive in ascending word order
// - mem_resp_data   in   DATA_W  refill beat data
// BEHAVIOUR
// - Reset (reset == 0, async): state = IDLE, all valid bits cleared, beat counter = 0.
//   All outputs are 0 except req_ready = 1 once reset is released.
// - Tag, valid and data arrays are flops; lookup is combinational on address.
// - IDLE: req_ready = !flush.
//   - Accepted hit: data_valid = 1 with the hit word on the next cycle (latency 1).
//     Stay in IDLE; back-to-back hits are one per cycle.
//   - Accepted miss: latch index, tag and word offset (addr[4:3]); go to MREQ.
// - MREQ: req_ready = 0; mem_req_valid = 1; mem_req_addr = {tag, index, 5'b0}.
//   Go to REFILL on mem_req_ready.
// - REFILL: req_ready = 0.
//   - Each mem_resp_valid writes data[index][beat] and increments the 2-bit beat counter.
//   - The beat where beat == latched offset is captured into the response register.
//   - After beat LINE_WORDS-1: write the tag; set valid unless a flush was seen during
//     MREQ/REFILL; counter wraps to 0; go to RESP.
// - RESP: data_valid = 1 with the captured word for exactly one cycle; req_ready = 0;
//   next state is IDLE. No critical-word-first: the response always follows the full
//   line.
// - Flush:
//   - In IDLE: clears all valid bits that cycle. Flush wins over a simultaneous
//     request, which is not accepted.
//   - In MREQ/REFILL/RESP: clears valid bits immediately and marks the pending line
//     not-valid. The in-flight response is still delivered.
// - data_valid is never asserted except in the hit-return cycle or RESP.
//   read_data = 0 when data_valid = 0.
// - Refill eviction overwrites the indexed line unconditionally; there are no dirty
//   lines.
// - Reset mid-refill aborts the refill. The memory side shares the same reset, so no
//   stale beats arrive afterwards.
// CONFIGURATION
// - ICACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0].
//   - Each increments once per accepted request of that kind and saturates at
//     32'hFFFF_FFFF.
//   - Both reset to 0; flush does not clear them.
// - ICACHE_STATS_EN undefined: neither the ports nor the counters exist. The rest of
//   the behaviour is identical.
// TESTING
// - Reset: hold reset = 0 with read_enable = 1 -> data_valid = 0, mem_req_valid = 0;
//   after release, req_ready = 1.
// - Cold miss at 0x1010:
//   - mem_req_addr = 0x1000.
//   - Beats 0xA0..0xA3 -> read_data = 0xA2 on the cycle after the 4th beat; one
//     data_valid pulse.
// - Hit: after the cold miss, request 0x1018 -> data_valid = 1, read_data = 0xA3 one
//   cycle later, no mem_req_valid. Back-to-back 0x1000, 0x1008 -> 0xA0, 0xA1 on
//   consecutive cycles.
// - Conflict: 0x1000 filled, then 0x1800 (same index 0) -> miss, refill from 0x1800.
//   Re-request 0x1000 -> miss again.
// - Flush: flush during REFILL of 0x2000 -> the response is still delivered.
//   Re-request 0x2000 -> miss. flush with read_enable in IDLE -> req_ready = 0, no
//   response.
// - Stats (ICACHE_STATS_EN): the sequence above -> hit_count = 3, miss_count = 5.
//   Reset mid-REFILL -> state IDLE, counters 0, no data_valid.

Source files
------------

// File: rtl/instruction_cache_responder_if.sv
// Fetch-to-cache read interface plus the cache's burst-refill memory port.
// The cache is the slave; the fetch stage and memory model together form the master.
interface instruction_cache_responder_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              read_enable;
    logic [ADDR_W-1:0] address;
    logic              req_ready;
    logic              flush;
    logic [DATA_W-1:0] read_data;
    logic              data_valid;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport master (
        output read_enable, address, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, read_data, data_valid, mem_req_valid, mem_req_addr
    );

    modport slave (
        input  read_enable, address, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, read_data, data_valid, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/instruction_cache_responder.sv
// Direct-mapped read-only instruction cache with burst refill on miss.
// Optional ICACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module instruction_cache_responder #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned SETS       = 64
) (
    input  logic clk,
    input  logic reset,
    instruction_cache_responder_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int unsigned BYTE_W     = 3;
    localparam int unsigned LINE_WORDS = LINE_BYTES / 8;
    localparam int unsigned WORD_W     = $clog2(LINE_WORDS);
    localparam int unsigned INDEX_W    = $clog2(SETS);
    localparam int unsigned OFFS_W     = $clog2(LINE_BYTES);
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFS_W;

    typedef enum logic [1:0] {IDLE, MREQ, REFILL, RESP} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   beat_q, beat_d;
    logic [INDEX_W-1:0]  idx_q, idx_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   resp_q, resp_d;
    logic                flush_seen_q, flush_seen_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                data_valid_q, data_valid_d;
    logic [DATA_W-1:0]   read_data_q, read_data_d;
    logic                fill_we_c, line_done_c;

    logic [DATA_W-1:0]   data_mem [SETS][LINE_WORDS];
    logic [TAG_W-1:0]    tag_mem  [SETS];
    logic [SETS-1:0]     valid_q;

    logic [INDEX_W-1:0]  req_index_c;
    logic [TAG_W-1:0]    req_tag_c;
    logic [WORD_W-1:0]   req_word_c;
    logic                hit_c, accept_c;
    logic [BYTE_W-1:0]   addr_unused;

    // Combinational lookup on the incoming address
    assign req_index_c = bus.address[OFFS_W +: INDEX_W];
    assign req_tag_c   = bus.address[ADDR_W-1 -: TAG_W];
    assign req_word_c  = bus.address[BYTE_W +: WORD_W];
    assign addr_unused = bus.address[BYTE_W-1:0];
    assign hit_c       = valid_q[req_index_c] && (tag_mem[req_index_c] == req_tag_c);

    // Ready is held low while in reset; flush blocks acceptance in IDLE
    assign bus.req_ready = (state_q == IDLE) && reset && !bus.flush;
    assign accept_c      = bus.read_enable && bus.req_ready;

    assign bus.data_valid    = data_valid_q;
    assign bus.read_data     = read_data_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = {tag_q, idx_q, {OFFS_W{1'b0}}};

    // Next-state and next-output logic
    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        idx_d           = idx_q;
        tag_d           = tag_q;
        word_d          = word_q;
        resp_d          = resp_q;
        flush_seen_d    = flush_seen_q;
        mem_req_valid_d = mem_req_valid_q;
        data_valid_d    = 1'b0;
        read_data_d     = '0;
        fill_we_c       = 1'b0;
        line_done_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (hit_c) begin
                        data_valid_d = 1'b1;
                        read_data_d  = data_mem[req_index_c][req_word_c];
                    end else begin
                        idx_d           = req_index_c;
                        tag_d           = req_tag_c;
                        word_d          = req_word_c;
                        flush_seen_d    = 1'b0;
                        mem_req_valid_d = 1'b1;
                        state_d         = MREQ;
                    end
                end
            end
            MREQ: begin
                if (bus.flush) flush_seen_d = 1'b1;
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = REFILL;
                end
            end
            REFILL: begin
                if (bus.flush) flush_seen_d = 1'b1;
                if (bus.mem_resp_valid) begin
                    fill_we_c = 1'b1;
                    beat_d    = beat_q + WORD_W'(1);
                    if (beat_q == word_q) resp_d = bus.mem_resp_data;
                    // Last beat may itself be the requested word, so bypass resp_q
                    if (beat_q == WORD_W'(LINE_WORDS - 1)) begin
                        line_done_c  = 1'b1;
                        data_valid_d = 1'b1;
                        read_data_d  = (beat_q == word_q) ? bus.mem_resp_data : resp_q;
                        state_d      = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            idx_q           <= '0;
            tag_q           <= '0;
            word_q          <= '0;
            resp_q          <= '0;
            flush_seen_q    <= 1'b0;
            mem_req_valid_q <= 1'b0;
            data_valid_q    <= 1'b0;
            read_data_q     <= '0;
            valid_q         <= '0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            idx_q           <= idx_d;
            tag_q           <= tag_d;
            word_q          <= word_d;
            resp_q          <= resp_d;
            flush_seen_q    <= flush_seen_d;
            mem_req_valid_q <= mem_req_valid_d;
            data_valid_q    <= data_valid_d;
            read_data_q     <= read_data_d;
            // A flush at any point, including the final beat, leaves the new line invalid
            if (bus.flush) begin
                valid_q <= '0;
            end else if (line_done_c && !flush_seen_q) begin
                valid_q[idx_q] <= 1'b1;
            end
        end
    end

    // Line storage; contents are qualified by valid_q so no reset is needed
    always_ff @(posedge clk) begin
        if (fill_we_c) data_mem[idx_q][beat_q] <= bus.mem_resp_data;
        if (line_done_c) tag_mem[idx_q] <= tag_q;
    end

`ifdef ICACHE_STATS_EN
    // Saturating counters of accepted hits and misses; flush leaves them alone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept_c) begin
            if (hit_c) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_cache_responder.sv
// Directed bench for instruction_cache_responder: hand-sequenced misses, a hit
// vector table, flush and mid-refill reset scenarios.
module tb_instruction_cache_responder;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    instruction_cache_responder_if #(.ADDR_W(64), .DATA_W(64)) bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    instruction_cache_responder #(
        .ADDR_W(64), .DATA_W(64), .LINE_BYTES(32), .SETS(64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        logic        re;
        logic        fl;
        logic        exp_dv;
        logic [63:0] exp_data;
        logic        exp_ready;
    } vec_t;

    vec_t vecs [10];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic hit(input string n, input logic [63:0] addr, input logic [63:0] exp);
        bus.read_enable = 1'b1;
        bus.address     = addr;
        tick();
        bus.read_enable = 1'b0;
        check({n, "_dv"}, 64'(bus.data_valid), 64'd1);
        check({n, "_data"}, bus.read_data, exp);
        check({n, "_noreq"}, 64'(bus.mem_req_valid), 64'd0);
    endtask

    // Full miss: request, one stalled MREQ cycle, four beats, one response pulse
    task automatic miss_fill(input string n, input logic [63:0] addr, input logic [63:0] base,
                             input logic [63:0] exp, input int flush_beat, input bit gap);
        bus.read_enable = 1'b1;
        bus.address     = addr;
        #1;
        check({n, "_ready"}, 64'(bus.req_ready), 64'd1);
        tick();
        bus.read_enable = 1'b0;
        check({n, "_mreq"}, 64'(bus.mem_req_valid), 64'd1);
        check({n, "_maddr"}, bus.mem_req_addr, addr & ~64'h1F);
        check({n, "_dv_mreq"}, 64'(bus.data_valid), 64'd0);
        tick();
        check({n, "_mreq_hold"}, 64'(bus.mem_req_valid), 64'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        check({n, "_mreq_drop"}, 64'(bus.mem_req_valid), 64'd0);
        check({n, "_busy"}, 64'(bus.req_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (gap && i == 2) tick();
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = base + 64'(i);
            bus.flush          = (i == flush_beat);
            tick();
            bus.mem_resp_valid = 1'b0;
            bus.flush          = 1'b0;
            if (i < 3) check({n, "_dv_early"}, 64'(bus.data_valid), 64'd0);
        end
        check({n, "_resp_dv"}, 64'(bus.data_valid), 64'd1);
        check({n, "_resp_data"}, bus.read_data, exp);
        check({n, "_resp_ready"}, 64'(bus.req_ready), 64'd0);
        tick();
        check({n, "_pulse_end"}, 64'(bus.data_valid), 64'd0);
        check({n, "_data_zero"}, bus.read_data, 64'd0);
        check({n, "_idle_ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset              = 1'b0;
        bus.read_enable    = 1'b1;
        bus.address        = 64'h1010;
        bus.flush          = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;

        vecs[0] = '{64'h3020, 1'b1, 1'b0, 1'b1, 64'hE0, 1'b1};
        vecs[1] = '{64'h3028, 1'b1, 1'b0, 1'b1, 64'hE1, 1'b1};
        vecs[2] = '{64'h3030, 1'b1, 1'b0, 1'b1, 64'hE2, 1'b1};
        vecs[3] = '{64'h3038, 1'b1, 1'b0, 1'b1, 64'hE3, 1'b1};
        vecs[4] = '{64'h2000, 1'b1, 1'b0, 1'b1, 64'hD0, 1'b1};
        vecs[5] = '{64'h2018, 1'b1, 1'b0, 1'b1, 64'hD3, 1'b1};
        vecs[6] = '{64'h2004, 1'b1, 1'b0, 1'b1, 64'hD0, 1'b1};
        vecs[7] = '{64'h3020, 1'b0, 1'b0, 1'b0, 64'h00, 1'b1};
        vecs[8] = '{64'h3021, 1'b1, 1'b0, 1'b1, 64'hE0, 1'b1};
        vecs[9] = '{64'h3020, 1'b1, 1'b1, 1'b0, 64'h00, 1'b0};

        // Reset held with a pending request
        repeat (3) tick();
        check("rst_dv", 64'(bus.data_valid), 64'd0);
        check("rst_mreq", 64'(bus.mem_req_valid), 64'd0);
        check("rst_rdata", bus.read_data, 64'd0);
        check("rst_ready_low", 64'(bus.req_ready), 64'd0);
        bus.read_enable = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_ready_high", 64'(bus.req_ready), 64'd1);
        tick();

        // Cold miss, hits, back-to-back hits
        miss_fill("cold1010", 64'h1010, 64'hA0, 64'hA2, -1, 1'b0);
        hit("hit1018", 64'h1018, 64'hA3);
        bus.read_enable = 1'b1;
        bus.address     = 64'h1000;
        tick();
        check("b2b0_dv", 64'(bus.data_valid), 64'd1);
        check("b2b0_data", bus.read_data, 64'hA0);
        bus.address = 64'h1008;
        tick();
        bus.read_enable = 1'b0;
        check("b2b1_dv", 64'(bus.data_valid), 64'd1);
        check("b2b1_data", bus.read_data, 64'hA1);
        tick();
        check("b2b_end_dv", 64'(bus.data_valid), 64'd0);

        // Conflict on index 0 evicts and re-misses
        miss_fill("conf1800", 64'h1800, 64'hB0, 64'hB0, -1, 1'b0);
        miss_fill("conf1000", 64'h1000, 64'hA0, 64'hA0, -1, 1'b0);

        // Flush during refill still returns; line stays invalid
        miss_fill("fl2000", 64'h2000, 64'hD0, 64'hD0, 1, 1'b0);
        miss_fill("re2000", 64'h2000, 64'hD0, 64'hD0, -1, 1'b0);

        // Flush with request in IDLE: not accepted, nothing returned
        bus.read_enable = 1'b1;
        bus.flush       = 1'b1;
        bus.address     = 64'h2000;
        #1;
        check("idleflush_ready", 64'(bus.req_ready), 64'd0);
        tick();
        bus.read_enable = 1'b0;
        bus.flush       = 1'b0;
        check("idleflush_dv", 64'(bus.data_valid), 64'd0);
        check("idleflush_mreq", 64'(bus.mem_req_valid), 64'd0);
`ifdef ICACHE_STATS_EN
        check("stats_hits", 64'(hit_count), 64'd3);
        check("stats_misses", 64'(miss_count), 64'd5);
`endif

        // Last-beat capture with a gap between beats, then a second line
        miss_fill("f3038", 64'h3038, 64'hE0, 64'hE3, -1, 1'b1);
        miss_fill("f2008", 64'h2008, 64'hD0, 64'hD1, -1, 1'b0);

        for (int v = 0; v < 10; v++) begin
            bus.read_enable = vecs[v].re;
            bus.flush       = vecs[v].fl;
            bus.address     = vecs[v].addr;
            #1;
            check($sformatf("vec%0d_ready", v), 64'(bus.req_ready), 64'(vecs[v].exp_ready));
            tick();
            check($sformatf("vec%0d_dv", v), 64'(bus.data_valid), 64'(vecs[v].exp_dv));
            check($sformatf("vec%0d_data", v), bus.read_data, vecs[v].exp_data);
            check($sformatf("vec%0d_noreq", v), 64'(bus.mem_req_valid), 64'd0);
        end
        bus.read_enable = 1'b0;
        bus.flush       = 1'b0;

        // Reset in the middle of a refill
        bus.read_enable = 1'b1;
        bus.address     = 64'h3020;
        tick();
        bus.read_enable = 1'b0;
        check("abort_miss", 64'(bus.mem_req_valid), 64'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 64'h55 + 64'(i);
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_dv", 64'(bus.data_valid), 64'd0);
        check("abort_mreq", 64'(bus.mem_req_valid), 64'd0);
        check("abort_ready", 64'(bus.req_ready), 64'd0);
`ifdef ICACHE_STATS_EN
        check("abort_hits", 64'(hit_count), 64'd0);
        check("abort_misses", 64'(miss_count), 64'd0);
`endif
        tick();
        reset = 1'b1;
        #1;
        check("abort_rel_ready", 64'(bus.req_ready), 64'd1);
        tick();
        check("abort_rel_dv", 64'(bus.data_valid), 64'd0);
        miss_fill("after3020", 64'h3020, 64'hE0, 64'hE0, -1, 1'b0);
        hit("after3028", 64'h3028, 64'hE1);
`ifdef ICACHE_STATS_EN
        check("final_hits", 64'(hit_count), 64'd1);
        check("final_misses", 64'(miss_count), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
